biquad_coef_loader: RTL and testbench
=====================================

# biquad_coef_loader

Coefficient loader and double-buffered register bank for the cascaded biquad filter. It accepts a serial valid/ready stream of signed 16-bit coefficient words into a shadow bank. When a complete set has arrived, it commits the whole set atomically to the active bank. The active bank drives the `b_0/b_1/b_2/a_1/a_2` inputs of every biquad section, so a coefficient change never reaches a section half-written.

## Interface
- `N_SECTIONS`, 4: number of biquad sections served; 5·N_SECTIONS words per set.
- `B0_RESET`, 16'sh4000: reset/pass-through value of every section's b_0 (unity gain in Q2.14).
- `CLK` in 1: single clock; all logic on the rising edge.
- `RST` in 1: synchronous, active-low reset.
- `START` in 1: pulse; begins (or restarts) a load sequence.
- `LOAD_VALID` in 1: upstream word valid.
- `LOAD_DATA` in 16: signed coefficient word.
- `LOAD_READY` out 1: loader accepts a word this cycle.
- `BUSY` out 1: high whenever the state is not IDLE.
- `DONE` out 1: one-cycle pulse; the active bank has just been updated.
- `ERR` out 1: sticky checksum-mismatch flag (checksum build only; tied 0 otherwise).
- `COEF_B0`, `COEF_B1`, `COEF_B2`, `COEF_A1`, `COEF_A2` out 16·N_SECTIONS each: active coefficients; section k at bits [16k+15:16k].

## Operation
- **States:** IDLE, LOAD, CSUM (checksum build only), COMMIT.
- **Transfer:** occurs when `LOAD_VALID && LOAD_READY`. `LOAD_READY = (state==LOAD || state==CSUM) && !START`.
- **Word order:** section 0 b_0, b_1, b_2, a_1, a_2, then section 1, and so on. Word index `idx` runs 0..5N−1.
- Each transfer writes `shadow[idx]` and increments `idx`. The active bank is untouched during loading.
- **Transitions:**
  - IDLE→LOAD on START, with `idx`=0.
  - LOAD→COMMIT on the transfer with `idx`=5N−1 (no checksum), or LOAD→CSUM on that transfer (checksum build).
  - COMMIT→IDLE after one cycle. In COMMIT, `active <= shadow` for all 5N words, and DONE is set for the next cycle.
- **START in LOAD or CSUM:** restarts with `idx`=0. Any word presented that cycle is not accepted (READY low). Stale shadow words are overwritten by the new sequence.
- **START in COMMIT:** ignored; the commit completes.
- **Reset:**
  - State IDLE, `idx`=0.
  - Active and shadow banks: b_0=`B0_RESET`, all other coefficients 0, so the filter is pass-through.
  - Outputs: READY=0, BUSY=0, DONE=0, ERR=0.
- **Reset mid-load:** the sequence is discarded and the active bank returns to reset values.
- **Arithmetic:** no arithmetic on coefficients; words are stored bit-exact.

## Timing
- Last word accepted in cycle t:
  - The state is COMMIT in t+1.
  - New coefficients appear on the `COEF_*` outputs in cycle t+2, with DONE=1 in that same cycle only.
- All five coefficients of all sections change on the same edge.
- BUSY rises the cycle after START and falls in the cycle DONE is high.
- No combinational path from LOAD_DATA to any output. `LOAD_READY` depends combinationally on START only.
- Throughput: one word per cycle with VALID held high. A full set takes 5N transfers + 2 cycles.

## Configuration
- `COEF_CHECKSUM_EN` defined:
  - After the 5N coefficients, one extra checksum word is accepted in CSUM.
  - A match requires the 16-bit modulo-2^16 sum of all 5N words plus the checksum word to equal 0.
  - Match → COMMIT. Mismatch → IDLE, no commit, ERR set.
  - ERR is sticky; it is cleared by the next START or by reset.
- `COEF_CHECKSUM_EN` undefined: no CSUM state, no sum register, ERR tied 0, LOAD goes straight to COMMIT.

## Structure
- **Shared package `biquad_pkg`:**
  - Constants: COEF_W=16, WORDS_PER_SECTION=5.
  - Coefficient-slot enum: B0, B1, B2, A1, A2.
  - Loader state enum.
- **Sub-module `i16_coef_bank`:** one per section. Holds the shadow and active registers for five words, with a write-enable/slot select and a commit strobe. The loader instantiates it N_SECTIONS times and decodes `idx` into section and slot.

## Test plan
- **Reset:** release RST → all `COEF_B0` slices = 16'h4000, others 0; BUSY=0, READY=0.
- **Full load, N=4, VALID held:** START, then 20 words 0x0001..0x0014 → outputs unchanged until 2 cycles after word 20. Then section 3 shows b_0=0x0010, a_2=0x0014, with DONE high for exactly 1 cycle.
- **Back-pressured stream:** VALID toggling randomly → the same final values; no word is lost or duplicated.
- **Restart:** START after 7 words, then a fresh 20 words 0x0100.. → final values come only from the second sequence; 1 DONE pulse total.
- **Checksum build:** 20 words plus a correct checksum → commit. The same set with the checksum +1 → no commit, ERR=1, outputs retain the previous set. The next START clears ERR.
- **Reset asserted mid-load (word 10):** state IDLE, active bank back to reset values, DONE never pulses.

Source files
------------

// File: rtl/biquad_pkg.sv
// Shared types and constants for the biquad coefficient loader.
// Build option COEF_CHECKSUM_EN adds the CSUM loader state.
package biquad_pkg;

    localparam int COEF_W            = 16;
    localparam int WORDS_PER_SECTION = 5;

    // Encoding doubles as the word offset within a section's five-word group
    typedef enum logic [2:0] {
        B0 = 3'd0,
        B1 = 3'd1,
        B2 = 3'd2,
        A1 = 3'd3,
        A2 = 3'd4
    } coef_slot_e;

`ifdef COEF_CHECKSUM_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_CSUM   = 2'd2,
        ST_COMMIT = 2'd3
    } loader_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd3
    } loader_state_e;
`endif

endpackage

// File: rtl/biquad_coef_loader_if.sv
// Serial valid/ready stream carrying signed 16-bit coefficient words.
interface biquad_coef_loader_if;
    logic                            valid;
    logic                            ready;
    logic [biquad_pkg::COEF_W-1:0]   data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/i16_coef_bank.sv
// Shadow/active register pair for the five coefficients of one biquad section.
module i16_coef_bank
    import biquad_pkg::*;
#(
    parameter logic [COEF_W-1:0] B0_RESET = 16'h4000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  coef_slot_e        slot_i,
    input  logic [COEF_W-1:0] wdata_i,
    input  logic              commit_i,
    output logic [COEF_W-1:0] b0_o,
    output logic [COEF_W-1:0] b1_o,
    output logic [COEF_W-1:0] b2_o,
    output logic [COEF_W-1:0] a1_o,
    output logic [COEF_W-1:0] a2_o
);

    logic [COEF_W-1:0] shadow_q [WORDS_PER_SECTION];
    logic [COEF_W-1:0] active_q [WORDS_PER_SECTION];

    // Both banks reset to a pass-through section: b0 = unity, everything else 0
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < WORDS_PER_SECTION; i++) begin
                shadow_q[i] <= (i == int'(B0)) ? B0_RESET : '0;
                active_q[i] <= (i == int'(B0)) ? B0_RESET : '0;
            end
        end else begin
            if (we_i) begin
                shadow_q[slot_i] <= wdata_i;
            end
            if (commit_i) begin
                active_q <= shadow_q;
            end
        end
    end

    assign b0_o = active_q[B0];
    assign b1_o = active_q[B1];
    assign b2_o = active_q[B2];
    assign a1_o = active_q[A1];
    assign a2_o = active_q[A2];

endmodule

// File: rtl/biquad_coef_loader.sv
// Coefficient loader: streams a full set into shadow banks, then commits all sections at once.
// Build option COEF_CHECKSUM_EN adds a trailing checksum word and the sticky ERR flag.
module biquad_coef_loader
    import biquad_pkg::*;
#(
    parameter int                N_SECTIONS = 4,
    parameter logic [COEF_W-1:0] B0_RESET   = 16'h4000
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    biquad_coef_loader_if.slave          load_if,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o,
    output logic [COEF_W*N_SECTIONS-1:0] coef_b0_o,
    output logic [COEF_W*N_SECTIONS-1:0] coef_b1_o,
    output logic [COEF_W*N_SECTIONS-1:0] coef_b2_o,
    output logic [COEF_W*N_SECTIONS-1:0] coef_a1_o,
    output logic [COEF_W*N_SECTIONS-1:0] coef_a2_o
);

    localparam int SEC_W = (N_SECTIONS > 1) ? $clog2(N_SECTIONS) : 1;

    loader_state_e     state_q, state_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    coef_slot_e        slot_q, slot_d;
    logic              done_q, done_d;
    logic              ready;
    logic              xfer;
    logic              last_word;
    logic              commit;

`ifdef COEF_CHECKSUM_EN
    logic [COEF_W-1:0] sum_q, sum_d;
    logic [COEF_W-1:0] csum_total;
    logic              err_q, err_d;
`endif

    // The word index idx is kept pre-split as (section, slot) so the bank decode is trivial
    always_comb begin
        state_d   = state_q;
        sec_d     = sec_q;
        slot_d    = slot_q;
        done_d    = 1'b0;
        commit    = 1'b0;
`ifdef COEF_CHECKSUM_EN
        sum_d      = sum_q;
        err_d      = err_q;
        csum_total = sum_q + load_if.data;
        ready      = ((state_q == ST_LOAD) || (state_q == ST_CSUM)) && !start_i;
`else
        ready      = (state_q == ST_LOAD) && !start_i;
`endif
        xfer      = load_if.valid && ready;
        last_word = (sec_q == SEC_W'(N_SECTIONS - 1)) && (slot_q == A2);

        if (start_i && (state_q != ST_COMMIT)) begin
            state_d = ST_LOAD;
            sec_d   = '0;
            slot_d  = B0;
`ifdef COEF_CHECKSUM_EN
            sum_d   = '0;
            err_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (xfer) begin
`ifdef COEF_CHECKSUM_EN
                        sum_d   = csum_total;
                        state_d = last_word ? ST_CSUM : ST_LOAD;
`else
                        state_d = last_word ? ST_COMMIT : ST_LOAD;
`endif
                        if (slot_q == A2) begin
                            slot_d = B0;
                            sec_d  = sec_q + 1'b1;
                        end else begin
                            slot_d = coef_slot_e'(slot_q + 3'd1);
                        end
                    end
                end
`ifdef COEF_CHECKSUM_EN
                ST_CSUM: begin
                    if (xfer) begin
                        if (csum_total == '0) begin
                            state_d = ST_COMMIT;
                        end else begin
                            state_d = ST_IDLE;
                            err_d   = 1'b1;
                        end
                    end
                end
`endif
                ST_COMMIT: begin
                    commit  = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            sec_q   <= '0;
            slot_q  <= B0;
            done_q  <= 1'b0;
`ifdef COEF_CHECKSUM_EN
            sum_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            slot_q  <= slot_d;
            done_q  <= done_d;
`ifdef COEF_CHECKSUM_EN
            sum_q   <= sum_d;
            err_q   <= err_d;
`endif
        end
    end

    assign load_if.ready = ready;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;
`ifdef COEF_CHECKSUM_EN
    assign err_o         = err_q;
`else
    assign err_o         = 1'b0;
`endif

    for (genvar gi = 0; gi < N_SECTIONS; gi++) begin : g_sec
        logic we;
        assign we = xfer && (state_q == ST_LOAD) && (sec_q == SEC_W'(gi));

        i16_coef_bank #(
            .B0_RESET (B0_RESET)
        ) u_bank (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .we_i     (we),
            .slot_i   (slot_q),
            .wdata_i  (load_if.data),
            .commit_i (commit),
            .b0_o     (coef_b0_o[COEF_W*gi +: COEF_W]),
            .b1_o     (coef_b1_o[COEF_W*gi +: COEF_W]),
            .b2_o     (coef_b2_o[COEF_W*gi +: COEF_W]),
            .a1_o     (coef_a1_o[COEF_W*gi +: COEF_W]),
            .a2_o     (coef_a2_o[COEF_W*gi +: COEF_W])
        );
    end

endmodule

// File: tb/tb_biquad_coef_loader.sv
// Scoreboard bench for biquad_coef_loader; checksum scenarios run only when COEF_CHECKSUM_EN is defined.
module tb_biquad_coef_loader;
    import biquad_pkg::*;

    localparam int N = 4;
    localparam int W = 16 * N;

    typedef struct packed {
        logic [W-1:0] b0;
        logic [W-1:0] b1;
        logic [W-1:0] b2;
        logic [W-1:0] a1;
        logic [W-1:0] a2;
    } set_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         busy, done, err;
    logic [W-1:0] b0, b1, b2, a1, a2;

    biquad_coef_loader_if lif ();

    biquad_coef_loader #(
        .N_SECTIONS (N),
        .B0_RESET   (16'h4000)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .start_i   (start),
        .load_if   (lif),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err),
        .coef_b0_o (b0),
        .coef_b1_o (b1),
        .coef_b2_o (b2),
        .coef_a1_o (a1),
        .coef_a2_o (a2)
    );

    always #5 clk = ~clk;

    set_t exp_q[$];
    set_t cur_exp;
    set_t prev_obs;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   exp_done = 0;

    task automatic chk(input string name, input logic [5*W-1:0] act, input logic [5*W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic set_t observed();
        set_t s;
        s = {b0, b1, b2, a1, a2};
        return s;
    endfunction

    function automatic set_t reset_set();
        set_t s;
        s    = '0;
        s.b0 = {N{16'h4000}};
        return s;
    endfunction

    // Word i of a set is base + i*step, laid out section-major, slot order b0,b1,b2,a1,a2
    function automatic set_t make_set(input logic [15:0] base, input logic [15:0] step);
        set_t        s;
        logic [15:0] w;
        s = '0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < 5; j++) begin
                w = base + 16'(5 * k + j) * step;
                case (j)
                    0: s.b0[16*k +: 16] = w;
                    1: s.b1[16*k +: 16] = w;
                    2: s.b2[16*k +: 16] = w;
                    3: s.a1[16*k +: 16] = w;
                    default: s.a2[16*k +: 16] = w;
                endcase
            end
        end
        return s;
    endfunction

    // Monitor: pops the scoreboard on every DONE, otherwise the outputs must hold still
    always @(negedge clk) begin
        set_t obs;
        set_t e;
        obs = observed();
        if (rst_n) begin
            if (done) begin
                done_cnt++;
                $display("commit %0d: b0=%h a2=%h", done_cnt, b0, a2);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    e = exp_q.pop_front();
                    chk("commit_b0", b0, e.b0);
                    chk("commit_b1", b1, e.b1);
                    chk("commit_b2", b2, e.b2);
                    chk("commit_a1", a1, e.a1);
                    chk("commit_a2", a2, e.a2);
                end
            end else begin
                chk("hold_without_done", obs, prev_obs);
            end
        end
        prev_obs = obs;
    end

    // START pulse with a junk word on the bus: it must never be accepted
    task automatic start_pulse();
        start     = 1'b1;
        lif.valid = 1'b1;
        lif.data  = 16'hDEAD;
        #1;
        chk("ready_low_during_start", lif.ready, 1'b0);
        @(negedge clk);
        start     = 1'b0;
        lif.valid = 1'b0;
        #1;
        chk("busy_after_start", busy, 1'b1);
        chk("err_clear_after_start", err, 1'b0);
    endtask

    // Called at a negedge; returns at the negedge right after the word was taken
    task automatic put_word(input logic [15:0] w, input int gaps);
        int waited;
        waited = 0;
        repeat (gaps) begin
            lif.valid = 1'b0;
            @(negedge clk);
        end
        lif.valid = 1'b1;
        lif.data  = w;
        #1;
        while (!lif.ready) begin
            @(negedge clk);
            #1;
            waited++;
            if (waited > 20) begin
                n_checks++;
                n_fail++;
                $display("FAIL ready_timeout actual=0 required=1");
                lif.valid = 1'b0;
                return;
            end
        end
        @(negedge clk);
    endtask

    task automatic send_set(input logic [15:0] base, input logic [15:0] step,
                            input bit backpressure, input logic [15:0] csum_delta);
        set_t        nxt;
        logic [15:0] w;
        logic [15:0] sum;
        bit          commit_exp;
        nxt        = make_set(base, step);
        sum        = '0;
        commit_exp = 1'b1;
        start_pulse();
        for (int i = 0; i < 5 * N; i++) begin
            w   = base + 16'(i) * step;
            sum = sum + w;
            put_word(w, backpressure ? int'($urandom_range(0, 2)) : 0);
        end
`ifdef COEF_CHECKSUM_EN
        put_word(16'h0000 - sum + csum_delta, 0);
        commit_exp = (csum_delta == 16'h0000);
`endif
        if (commit_exp) begin
            exp_q.push_back(nxt);
            exp_done++;
        end
        lif.valid = 1'b0;
        chk("done_low_t1", done, 1'b0);
        chk("outputs_old_t1", observed(), cur_exp);
`ifdef COEF_CHECKSUM_EN
        chk("err_after_csum", err, !commit_exp);
`endif
        @(negedge clk);
        chk("done_t2", done, commit_exp);
        chk("busy_low_t2", busy, 1'b0);
        if (commit_exp) cur_exp = nxt;
        chk("outputs_t2", observed(), cur_exp);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        lif.valid = 1'b0;
        lif.data  = '0;
        cur_exp   = reset_set();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_coefs", observed(), reset_set());
        chk("reset_busy", busy, 1'b0);
        chk("reset_ready", lif.ready, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_err", err, 1'b0);
        @(negedge clk);

        // Full load 0x0001..0x0014 with VALID held
        send_set(16'h0001, 16'h0001, 1'b0, 16'h0000);
        chk("sec3_b0", b0[63:48], 16'h0010);
        chk("sec3_a2", a2[63:48], 16'h0014);
        chk("sec0_b1", b1[15:0],  16'h0002);
        chk("sec2_a1", a1[47:32], 16'h000E);

        // Back-pressured stream with negative words
        send_set(16'h8000, 16'h0123, 1'b1, 16'h0000);
        chk("bp_sec1_b2", b2[31:16], 16'h8000 + 16'd7 * 16'h0123);

        // Restart after 7 words; only the second sequence may reach the outputs
        start_pulse();
        for (int i = 0; i < 7; i++) put_word(16'h0300 + 16'(i), 0);
        send_set(16'h0100, 16'h0001, 1'b0, 16'h0000);
        chk("restart_sec0_b0", b0[15:0], 16'h0100);
        chk("restart_sec3_a2", a2[63:48], 16'h0113);

`ifdef COEF_CHECKSUM_EN
        send_set(16'h0200, 16'h0001, 1'b0, 16'h0000);
        send_set(16'h0900, 16'h0001, 1'b0, 16'h0001);
        repeat (3) @(negedge clk);
        chk("err_sticky", err, 1'b1);
        chk("retain_after_bad_csum", observed(), make_set(16'h0200, 16'h0001));
`endif

        // Reset asserted after word 10 of a load
        start_pulse();
        for (int i = 0; i < 10; i++) put_word(16'h0700 + 16'(i), 0);
        lif.valid = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        cur_exp = reset_set();
        chk("midload_reset_coefs", observed(), reset_set());
        chk("midload_reset_busy", busy, 1'b0);
        chk("midload_reset_ready", lif.ready, 1'b0);
        repeat (20) @(negedge clk);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("done_pulse_count", 32'(done_cnt), 32'(exp_done));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
